// File: rtl/eq_band_gain_mixer.sv
// eq_band_gain_mixer: weights eight FIR band outputs by a programmable
// signed Q1.6 gain table, sums them with one time-multiplexed MAC, then
// rounds half-up and saturates to a signed 16-bit sample.
// Ports: clk, rst (async, active-low), ena, band_in/in_valid/in_ready,
//   gain_we/gain_addr/gain_wdata, out_sample/out_valid/sat_flag,
//   peak_clr/peak_out (only with EQ_PEAK_METER_EN defined).
// Build option: EQ_PEAK_METER_EN adds a peak |out_sample| meter.
module eq_band_gain_mixer #(
    parameter int NUM_BANDS = 8,
    parameter int BAND_W    = 32,
    parameter int GAIN_W    = 8,
    parameter int OUT_W     = 16,
    parameter int SHIFT     = 21
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic [NUM_BANDS*BAND_W-1:0] band_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        gain_we,
    input  logic [$clog2(NUM_BANDS)-1:0] gain_addr,
    input  logic [GAIN_W-1:0]           gain_wdata,
    output logic [OUT_W-1:0]            out_sample,
    output logic                        out_valid,
    output logic                        sat_flag
`ifdef EQ_PEAK_METER_EN
    ,
    input  logic                        peak_clr,
    output logic [OUT_W-2:0]            peak_out
`endif
);

    localparam int IDX_W  = $clog2(NUM_BANDS);
    localparam int PROD_W = BAND_W + GAIN_W;
    localparam int ACC_W  = PROD_W + IDX_W;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BANDS - 1);
    localparam logic signed [GAIN_W-1:0] UNITY = GAIN_W'(1) << (GAIN_W - 2);
    localparam logic signed [ACC_W-1:0]  RND   = ACC_W'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0]  MAXV  = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0]  MINV  = ~MAXV;

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} state_t;

    state_t                    r_state;
    logic [IDX_W-1:0]          r_idx;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [BAND_W-1:0]  r_band [NUM_BANDS];
    logic signed [GAIN_W-1:0]  r_gain [NUM_BANDS];
    logic signed [GAIN_W-1:0]  r_snap [NUM_BANDS];
    logic [OUT_W-1:0]          r_out;
    logic                      r_valid;
    logic                      r_sat;

    logic signed [PROD_W-1:0]  w_bx;
    logic signed [PROD_W-1:0]  w_gx;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_prod_x;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_shr;
    logic signed [OUT_W-1:0]   w_res;
    logic                      w_clip;
    logic                      w_emit;

    assign in_ready   = (r_state == ST_IDLE) && ena;
    assign out_sample = r_out;
    assign out_valid  = r_valid;
    assign sat_flag   = r_sat;
    assign w_emit     = ena && (r_state == ST_OUT);

    // Operands are sign-extended to the full product width first.
    assign w_bx = $signed({{GAIN_W{r_band[r_idx][BAND_W-1]}}, r_band[r_idx]});
    assign w_gx = $signed({{BAND_W{r_snap[r_idx][GAIN_W-1]}}, r_snap[r_idx]});
    assign w_prod   = w_bx * w_gx;
    assign w_prod_x = $signed({{IDX_W{w_prod[PROD_W-1]}}, w_prod});

    // Round half up, then floor-shift; acc headroom makes the add safe.
    assign w_sum = r_acc + RND;
    assign w_shr = w_sum >>> SHIFT;

    always_comb begin
        w_res  = w_shr[OUT_W-1:0];
        w_clip = 1'b0;
        if (w_shr > MAXV) begin
            w_res  = MAXV[OUT_W-1:0];
            w_clip = 1'b1;
        end else if (w_shr < MINV) begin
            w_res  = MINV[OUT_W-1:0];
            w_clip = 1'b1;
        end
    end

    // Gain table is writable at any time; the MAC only sees r_snap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_BANDS; k++) r_gain[k] <= UNITY;
        end else if (gain_we) begin
            r_gain[gain_addr] <= gain_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
            for (int k = 0; k < NUM_BANDS; k++) begin
                r_band[k] <= '0;
                r_snap[k] <= UNITY;
            end
        end else begin
            r_valid <= 1'b0;
            if (ena) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (in_valid) begin
                            for (int k = 0; k < NUM_BANDS; k++) begin
                                r_band[k] <= band_in[k*BAND_W +: BAND_W];
                                r_snap[k] <= r_gain[k];
                            end
                            r_acc   <= '0;
                            r_idx   <= '0;
                            r_state <= ST_MAC;
                        end
                    end
                    ST_MAC: begin
                        r_acc <= r_acc + w_prod_x;
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == LAST) r_state <= ST_OUT;
                    end
                    ST_OUT: begin
                        r_out   <= w_res;
                        r_sat   <= w_clip;
                        r_valid <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef EQ_PEAK_METER_EN
    logic [OUT_W-2:0] r_peak;
    logic [OUT_W-1:0] w_neg;
    logic [OUT_W-2:0] w_abs;

    // |-32768| does not fit in OUT_W-1 bits, so it clamps to all ones.
    assign w_neg = -w_res;
    always_comb begin
        w_abs = w_res[OUT_W-2:0];
        if (w_res[OUT_W-1]) begin
            if (w_res == MINV[OUT_W-1:0]) w_abs = '1;
            else                          w_abs = w_neg[OUT_W-2:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_peak <= '0;
        end else if (w_emit) begin
            if (peak_clr || (w_abs > r_peak)) r_peak <= w_abs;
        end else if (peak_clr) begin
            r_peak <= '0;
        end
    end

    assign peak_out = r_peak;
`endif

endmodule

// File: tb/tb_eq_band_gain_mixer.sv
// Bench for eq_band_gain_mixer: directed cases plus random band/gain
// sets checked against an integer arithmetic reference model.
module tb_eq_band_gain_mixer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ena = 1'b0;
    logic [255:0] band_in = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         gain_we = 1'b0;
    logic [2:0]   gain_addr = '0;
    logic [7:0]   gain_wdata = '0;
    logic [15:0]  out_sample;
    logic         out_valid;
    logic         sat_flag;
`ifdef EQ_PEAK_METER_EN
    logic         peak_clr = 1'b0;
    logic [14:0]  peak_out;
`endif

    int total = 0;
    int bad   = 0;

    logic signed [31:0] bm [8];
    logic signed [7:0]  gm [8];

    always #5 clk = ~clk;

    eq_band_gain_mixer dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .band_in    (band_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .gain_we    (gain_we),
        .gain_addr  (gain_addr),
        .gain_wdata (gain_wdata),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .sat_flag   (sat_flag)
`ifdef EQ_PEAK_METER_EN
        ,
        .peak_clr   (peak_clr),
        .peak_out   (peak_out)
`endif
    );

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: exact integer sum, floor((sum + 2^20) / 2^21), clip.
    task automatic model(output logic signed [63:0] e, output logic s);
        longint acc;
        longint r;
        acc = 0;
        for (int i = 0; i < 8; i++) acc += longint'(bm[i]) * longint'(gm[i]);
        r = (acc + (longint'(1) <<< 20)) >>> 21;
        s = 1'b0;
        if (r > 32767) begin
            r = 32767;
            s = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            s = 1'b1;
        end
        e = r;
    endtask

    task automatic pack();
        for (int i = 0; i < 8; i++) band_in[i*32 +: 32] = bm[i];
    endtask

    task automatic set_gain(input int a, input logic signed [7:0] v);
        @(negedge clk);
        gain_we    = 1'b1;
        gain_addr  = 3'(a);
        gain_wdata = v;
        @(negedge clk);
        gain_we = 1'b0;
        gm[a]   = v;
    endtask

    task automatic set_all(input logic signed [31:0] v);
        for (int i = 0; i < 8; i++) bm[i] = v;
    endtask

    task automatic wait_ready(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            if (in_ready) seen = 1'b1;
            else @(negedge clk);
        end
        chk({tag, ".ready"}, seen, 1);
    endtask

    // One sample; optional ena stall and optional gain[0]=0 write on the
    // accept edge (which must not reach this sample's snapshot).
    task automatic run(input string tag, input int st_at, input int st_len,
                       input bit wr_acc);
        logic signed [63:0] e;
        logic s;
        int cyc;
        bit ok;
        model(e, s);
        @(negedge clk);
        pack();
        in_valid = 1'b1;
        wait_ready(tag);
        if (wr_acc) begin
            gain_we    = 1'b1;
            gain_addr  = 3'd0;
            gain_wdata = 8'd0;
        end
        cyc = 0;
        ok  = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                in_valid = 1'b0;
                gain_we  = 1'b0;
            end
            if (out_valid) ok = 1'b1;
            else if (st_len > 0 && cyc == st_at) ena = 1'b0;
            else if (st_len > 0 && cyc == st_at + st_len) ena = 1'b1;
        end
        ena = 1'b1;
        if (wr_acc) gm[0] = 8'sd0;
        chk({tag, ".lat"}, cyc, 10 + st_len);
        chk({tag, ".smp"}, $signed(out_sample), e);
        chk({tag, ".sat"}, sat_flag, s);
    endtask

    initial begin : main
        logic signed [63:0] e1;
        logic signed [63:0] e2;
        logic s1;
        logic s2;
        int cyc;
        int nv;
        int t1;
        int t2;
        logic signed [63:0] o1;
        logic signed [63:0] o2;
        int vseen;

        for (int i = 0; i < 8; i++) gm[i] = 8'sd64;

        repeat (3) @(negedge clk);
        chk("rst.out", out_sample, 0);
        chk("rst.valid", out_valid, 0);
        chk("rst.sat", sat_flag, 0);
        rst = 1'b1;
        ena = 1'b1;
        @(negedge clk);
        chk("rst.ready", in_ready, 1);
`ifdef EQ_PEAK_METER_EN
        chk("rst.peak", peak_out, 0);
`endif

        for (int i = 0; i < 8; i++) bm[i] = $signed(32'($urandom)) >>> 10;
        run("unity", 0, 0, 1'b0);
        set_gain(0, 8'sd64);

        set_all(32'sd32768);
        run("t2", 0, 0, 1'b0);

        set_gain(0, 8'sd127);
        for (int i = 1; i < 8; i++) set_gain(i, 8'sd0);
        set_all(32'h7FFF_FFFF);
        bm[0] = 32'h0100_0000;
        run("t3", 0, 0, 1'b0);

        for (int i = 0; i < 8; i++) set_gain(i, 8'sd64);
        set_all(32'h7FFF_FFFF);
        run("satp", 0, 0, 1'b0);
        set_all(32'h8000_0000);
        run("satn", 0, 0, 1'b0);
`ifdef EQ_PEAK_METER_EN
        chk("peak.max", peak_out, 32767);
        @(negedge clk);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        chk("peak.clr", peak_out, 0);
`endif

        set_all(32'sd0);
        bm[0] = 32'sd16384;
        run("rnd.p", 0, 0, 1'b0);
`ifdef EQ_PEAK_METER_EN
        chk("peak.one", peak_out, 1);
`endif
        bm[0] = -32'sd16384;
        run("rnd.n", 0, 0, 1'b0);

        set_all(32'sd32768);
        run("stall", 3, 3, 1'b0);

        run("wracc", 0, 0, 1'b1);
        set_gain(0, 8'sd64);

        // Back-to-back with in_valid held; gain[0] rewritten mid-MAC.
        set_all(32'sd32768);
        model(e1, s1);
        gm[0] = 8'sd0;
        model(e2, s2);
        @(negedge clk);
        pack();
        in_valid = 1'b1;
        wait_ready("b2b");
        cyc = 0;
        nv  = 0;
        t1  = 0;
        t2  = 0;
        o1  = 0;
        o2  = 0;
        for (int k = 0; k < 40 && nv < 2; k++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 4) begin
                gain_we    = 1'b1;
                gain_addr  = 3'd0;
                gain_wdata = 8'd0;
            end
            if (cyc == 5) gain_we = 1'b0;
            if (cyc == 11) in_valid = 1'b0;
            if (out_valid) begin
                nv++;
                if (nv == 1) begin
                    t1 = cyc;
                    o1 = $signed(out_sample);
                end else begin
                    t2 = cyc;
                    o2 = $signed(out_sample);
                end
            end
        end
        chk("b2b.t1", t1, 10);
        chk("b2b.t2", t2, 20);
        chk("b2b.a", o1, e1);
        chk("b2b.b", o2, e2);
        set_gain(0, 8'sd64);

        // Reset mid-MAC: no output, gains back to unity.
        set_gain(3, -8'sd5);
        for (int i = 0; i < 8; i++) bm[i] = $signed(32'($urandom)) >>> 8;
        @(negedge clk);
        pack();
        in_valid = 1'b1;
        wait_ready("mid");
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) gm[i] = 8'sd64;
        vseen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) vseen++;
        end
        chk("mid.novalid", vseen, 0);
        chk("mid.out", out_sample, 0);
        run("mid.unity", 0, 0, 1'b0);

        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 8; i++) begin
                set_gain(i, 8'($urandom_range(0, 255)));
                bm[i] = $signed(32'($urandom)) >>> $urandom_range(0, 14);
            end
            if (n % 4 == 3)
                run("rand", int'($urandom_range(1, 8)), int'($urandom_range(1, 3)), 1'b0);
            else
                run("rand", 0, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
